i2c_reg_bridge: RTL and testbench

I2C_REG_BRIDGE -- requirements
Module: i2c_reg_bridge

---
 rtl/i2c_reg_pkg.sv | 12 +
 rtl/i2c_reg_file.sv | 33 +++
 rtl/i2c_reg_bridge.sv | 144 ++++++++++++++
 tb/tb_i2c_reg_bridge.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_pkg.sv
// Shared types and defaults for the I2C register bridge.
package i2c_reg_pkg;

  localparam int unsigned ADDR_WIDTH_DEF = 4;

  // Write-side state: is the next accepted byte a pointer or register data
  typedef enum logic {
    ST_PTR  = 1'b0,
    ST_DATA = 1'b1
  } wr_state_e;

endpackage

// File: rtl/i2c_reg_file.sv
// Byte-wide register file: one write port, one combinational read port, flat view of all registers.
module i2c_reg_file #(
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      we,
  input  logic [ADDR_WIDTH-1:0]     waddr,
  input  logic [7:0]                wdata,
  input  logic [ADDR_WIDTH-1:0]     raddr,
  output logic [7:0]                rdata_c,
  output logic [8*(1<<ADDR_WIDTH)-1:0] regs_flat
);

  localparam int unsigned DEPTH = 1 << ADDR_WIDTH;

  logic [7:0] mem [DEPTH];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= 8'h00;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata_c = mem[raddr];

  for (genvar g = 0; g < int'(DEPTH); g++) begin : g_flat
    assign regs_flat[8*g +: 8] = mem[g];
  end

endmodule

// File: rtl/i2c_reg_bridge.sv
// Bridges I2C slave byte streams to a register file: pointer byte then data bytes on writes, reads stream from the pointer.
// Build option: define I2C_REG_BRIDGE_AUTOINC_EN to advance the pointer after every data write and read.
module i2c_reg_bridge
  import i2c_reg_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [7:0]                   s_axis_wr_tdata,
  input  logic                         s_axis_wr_tvalid,
  output logic                         s_axis_wr_tready,
  input  logic                         s_axis_wr_tlast,
  output logic [7:0]                   m_axis_rd_tdata,
  output logic                         m_axis_rd_tvalid,
  input  logic                         m_axis_rd_tready,
  output logic                         m_axis_rd_tlast,
  output logic [8*(1<<ADDR_WIDTH)-1:0] regs_flat,
  output logic                         wr_pulse,
  output logic [ADDR_WIDTH-1:0]        wr_addr,
  output logic [7:0]                   wr_data,
  output logic                         rd_pulse,
  output logic [ADDR_WIDTH-1:0]        rd_addr
);

`ifdef I2C_REG_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  wr_state_e             state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d, ptr_step_c;
  logic                  tready_q;
  logic                  rd_valid_q, rd_valid_d;
  logic [7:0]            rd_data_q, rd_data_d;
  logic                  wr_pulse_q, wr_pulse_d;
  logic [ADDR_WIDTH-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]            wr_data_q, wr_data_d;
  logic                  rd_pulse_q, rd_pulse_d;
  logic [ADDR_WIDTH-1:0] rd_addr_q, rd_addr_d;
  logic                  reg_we_c;
  logic [7:0]            reg_rdata_c;
  logic                  accept_c;
  logic                  rd_hs_c;

  assign accept_c   = s_axis_wr_tvalid & tready_q;
  // Pending write bytes mask the read stream so the two never handshake together
  assign m_axis_rd_tvalid = rd_valid_q & ~s_axis_wr_tvalid;
  assign m_axis_rd_tdata  = rd_data_q;
  assign m_axis_rd_tlast  = 1'b0;
  assign rd_hs_c    = m_axis_rd_tvalid & m_axis_rd_tready;
  assign ptr_step_c = ptr_q + ADDR_WIDTH'(AUTOINC);

  assign s_axis_wr_tready = tready_q;
  assign wr_pulse = wr_pulse_q;
  assign wr_addr  = wr_addr_q;
  assign wr_data  = wr_data_q;
  assign rd_pulse = rd_pulse_q;
  assign rd_addr  = rd_addr_q;

  i2c_reg_file #(
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_reg_file (
    .clk       (clk),
    .rst_n     (rst_n),
    .we        (reg_we_c),
    .waddr     (ptr_q),
    .wdata     (s_axis_wr_tdata),
    .raddr     (ptr_q),
    .rdata_c   (reg_rdata_c),
    .regs_flat (regs_flat)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_PTR;
      ptr_q      <= '0;
      tready_q   <= 1'b0;
      rd_valid_q <= 1'b0;
      rd_data_q  <= 8'h00;
      wr_pulse_q <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= 8'h00;
      rd_pulse_q <= 1'b0;
      rd_addr_q  <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      tready_q   <= 1'b1;
      rd_valid_q <= rd_valid_d;
      rd_data_q  <= rd_data_d;
      wr_pulse_q <= wr_pulse_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      rd_pulse_q <= rd_pulse_d;
      rd_addr_q  <= rd_addr_d;
    end
  end

  // Write FSM, pointer update and read holding register refill
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    reg_we_c   = 1'b0;
    wr_pulse_d = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    rd_pulse_d = 1'b0;
    rd_addr_d  = rd_addr_q;
    rd_valid_d = rd_valid_q;
    rd_data_d  = rd_data_q;

    if (accept_c) begin
      case (state_q)
        ST_PTR: begin
          ptr_d   = s_axis_wr_tdata[ADDR_WIDTH-1:0];
          state_d = s_axis_wr_tlast ? ST_PTR : ST_DATA;
        end
        ST_DATA: begin
          reg_we_c   = 1'b1;
          wr_pulse_d = 1'b1;
          wr_addr_d  = ptr_q;
          wr_data_d  = s_axis_wr_tdata;
          ptr_d      = ptr_step_c;
          state_d    = s_axis_wr_tlast ? ST_PTR : ST_DATA;
        end
      endcase
    end else if (rd_hs_c) begin
      rd_pulse_d = 1'b1;
      rd_addr_d  = ptr_q;
      ptr_d      = ptr_step_c;
    end

    // Any pointer/data change invalidates the held byte; refill from the updated state next cycle
    if (accept_c || rd_hs_c) begin
      rd_valid_d = 1'b0;
    end else if (!rd_valid_q) begin
      rd_valid_d = 1'b1;
      rd_data_d  = reg_rdata_c;
    end
  end

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Scoreboard bench for i2c_reg_bridge; follows I2C_REG_BRIDGE_AUTOINC_EN the same way the design does.
module tb_i2c_reg_bridge;

  localparam int unsigned AW    = 4;
  localparam int unsigned DEPTH = 16;
`ifdef I2C_REG_BRIDGE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [7:0]    data;
  } ev_t;

  logic             clk = 1'b0;
  logic             rst_n;
  logic [7:0]       s_axis_wr_tdata;
  logic             s_axis_wr_tvalid;
  logic             s_axis_wr_tready;
  logic             s_axis_wr_tlast;
  logic [7:0]       m_axis_rd_tdata;
  logic             m_axis_rd_tvalid;
  logic             m_axis_rd_tready;
  logic             m_axis_rd_tlast;
  logic [8*DEPTH-1:0] regs_flat;
  logic             wr_pulse;
  logic [AW-1:0]    wr_addr;
  logic [7:0]       wr_data;
  logic             rd_pulse;
  logic [AW-1:0]    rd_addr;

  i2c_reg_bridge #(.ADDR_WIDTH(AW)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .s_axis_wr_tdata  (s_axis_wr_tdata),
    .s_axis_wr_tvalid (s_axis_wr_tvalid),
    .s_axis_wr_tready (s_axis_wr_tready),
    .s_axis_wr_tlast  (s_axis_wr_tlast),
    .m_axis_rd_tdata  (m_axis_rd_tdata),
    .m_axis_rd_tvalid (m_axis_rd_tvalid),
    .m_axis_rd_tready (m_axis_rd_tready),
    .m_axis_rd_tlast  (m_axis_rd_tlast),
    .regs_flat        (regs_flat),
    .wr_pulse         (wr_pulse),
    .wr_addr          (wr_addr),
    .wr_data          (wr_data),
    .rd_pulse         (rd_pulse),
    .rd_addr          (rd_addr)
  );

  always #5 clk = ~clk;

  ev_t           wr_q[$];
  ev_t           rd_q[$];
  logic [AW-1:0] rd_addr_q[$];
  logic [7:0]    m_regs [DEPTH];
  logic [AW-1:0] m_ptr;
  bit            m_data;
  int            n_tests = 0;
  int            n_fail  = 0;
  int            hs_cnt  = 0;
  bit            gap_pend = 1'b0;
  ev_t           mon_e;
  logic [AW-1:0] mon_a;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [8*DEPTH-1:0] model_flat();
    logic [8*DEPTH-1:0] f;
    for (int i = 0; i < int'(DEPTH); i++) f[8*i +: 8] = m_regs[i];
    return f;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(DEPTH); i++) m_regs[i] = 8'h00;
    m_ptr  = '0;
    m_data = 1'b0;
  endtask

  // Drive one write byte (left asserted so consecutive calls are back-to-back) and update the model
  task automatic send(input logic [7:0] d, input bit last);
    @(posedge clk); #1;
    s_axis_wr_tvalid = 1'b1;
    s_axis_wr_tdata  = d;
    s_axis_wr_tlast  = last;
    if (!m_data) begin
      m_ptr = d[AW-1:0];
    end else begin
      m_regs[m_ptr] = d;
      wr_q.push_back(ev_t'{addr: m_ptr, data: d});
      if (AUTOINC) m_ptr = m_ptr + AW'(1);
    end
    m_data = !last;
  endtask

  task automatic tx_end();
    @(posedge clk); #1;
    s_axis_wr_tvalid = 1'b0;
    s_axis_wr_tlast  = 1'b0;
    s_axis_wr_tdata  = 8'h00;
  endtask

  task automatic read_n(input int n);
    int target;
    for (int i = 0; i < n; i++) begin
      rd_q.push_back(ev_t'{addr: m_ptr, data: m_regs[m_ptr]});
      if (AUTOINC) m_ptr = m_ptr + AW'(1);
    end
    target = hs_cnt + n;
    @(posedge clk); #1;
    m_axis_rd_tready = 1'b1;
    for (int c = 0; c < 20 * n && hs_cnt < target; c++) @(posedge clk);
    chk("rd_done", 128'(hs_cnt), 128'(target));
    #1;
    m_axis_rd_tready = 1'b0;
  endtask

  // Output monitor: sampled mid-cycle, away from the active edge
  always @(negedge clk) begin
    if (rst_n) begin
      if (gap_pend) begin
        chk("rd_gap", 128'(m_axis_rd_tvalid), 128'(0));
        gap_pend = 1'b0;
      end
      if (s_axis_wr_tvalid) chk("rd_mask", 128'(m_axis_rd_tvalid), 128'(0));
      if (wr_pulse) begin
        if (wr_q.size() == 0) chk("wr_unexp", 128'(wr_pulse), 128'(0));
        else begin
          mon_e = wr_q.pop_front();
          chk("wr_addr", 128'(wr_addr), 128'(mon_e.addr));
          chk("wr_data", 128'(wr_data), 128'(mon_e.data));
        end
      end
      if (rd_pulse) begin
        if (rd_addr_q.size() == 0) chk("rd_unexp", 128'(rd_pulse), 128'(0));
        else begin
          mon_a = rd_addr_q.pop_front();
          chk("rd_addr", 128'(rd_addr), 128'(mon_a));
        end
      end
      if (m_axis_rd_tvalid && m_axis_rd_tready) begin
        hs_cnt++;
        gap_pend = 1'b1;
        chk("rd_tlast", 128'(m_axis_rd_tlast), 128'(0));
        if (rd_q.size() == 0) chk("rd_hs_unexp", 128'(1), 128'(0));
        else begin
          mon_e = rd_q.pop_front();
          chk("rd_data", 128'(m_axis_rd_tdata), 128'(mon_e.data));
          rd_addr_q.push_back(mon_e.addr);
        end
      end
    end
  end

  task automatic settle_and_check_regs(input string tag);
    repeat (3) @(posedge clk);
    #1;
    chk(tag, 128'(regs_flat), 128'(model_flat()));
  endtask

  task automatic reset_checks(input string tag);
    chk({tag, "_regs"},   128'(regs_flat), 128'(0));
    chk({tag, "_tready"}, 128'(s_axis_wr_tready), 128'(0));
    chk({tag, "_rdvld"},  128'(m_axis_rd_tvalid), 128'(0));
    chk({tag, "_wrp"},    128'(wr_pulse), 128'(0));
    chk({tag, "_rdp"},    128'(rd_pulse), 128'(0));
  endtask

  initial begin
    rst_n            = 1'b0;
    s_axis_wr_tdata  = 8'h00;
    s_axis_wr_tvalid = 1'b0;
    s_axis_wr_tlast  = 1'b0;
    m_axis_rd_tready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset_checks("rst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("tready_up", 128'(s_axis_wr_tready), 128'(1));

    // Pointer 3, two data bytes
    send(8'h03, 1'b0); send(8'h5A, 1'b0); send(8'hC3, 1'b1); tx_end();
    settle_and_check_regs("wr_burst");
    chk("reg3_const", 128'(regs_flat[31:24]), AUTOINC ? 128'(8'h5A) : 128'(8'hC3));

    // Wrap from register 15 to 0
    send(8'h0F, 1'b0); send(8'h11, 1'b0); send(8'h22, 1'b1); tx_end();
    settle_and_check_regs("wr_wrap");
    chk("reg0_const", 128'(regs_flat[7:0]), AUTOINC ? 128'(8'h22) : 128'(8'h00));

    // Pointer-only transaction then a 3-byte read
    send(8'h02, 1'b1); tx_end();
    read_n(3);

    // Repeated writes/reads at pointer 7
    send(8'h07, 1'b0); send(8'hAA, 1'b0); send(8'hBB, 1'b1); tx_end();
    settle_and_check_regs("wr_rep");
    send(8'h07, 1'b1); tx_end();
    read_n(2);

    // Upper pointer bits discarded
    send(8'h37, 1'b0); send(8'h99, 1'b1); tx_end();
    settle_and_check_regs("ptr_trunc");
    chk("reg7_const", 128'(regs_flat[63:56]), 128'(8'h99));

    // Randomised transactions followed by reads
    for (int t = 0; t < 6; t++) begin
      int nb;
      nb = $urandom_range(1, 3);
      send(8'($urandom_range(0, 255)), 1'b0);
      for (int b = 0; b < nb; b++) send(8'($urandom_range(0, 255)), b == nb - 1);
      tx_end();
      settle_and_check_regs("rand_wr");
      send(8'($urandom_range(0, 15)), 1'b1); tx_end();
      read_n(2);
    end

    // Reset in the middle of a transaction
    send(8'h05, 1'b0);
    @(posedge clk); #1;
    s_axis_wr_tvalid = 1'b0;
    rst_n = 1'b0;
    gap_pend = 1'b0;
    model_reset();
    #2;
    reset_checks("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    send(8'h01, 1'b0); send(8'h66, 1'b1); tx_end();
    settle_and_check_regs("post_rst");
    chk("reg1_const", 128'(regs_flat[15:8]), 128'(8'h66));
    read_n(1);

    repeat (4) @(posedge clk);
    chk("wr_q_empty", 128'(wr_q.size()), 128'(0));
    chk("rd_q_empty", 128'(rd_q.size()), 128'(0));
    chk("rd_addr_q_empty", 128'(rd_addr_q.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
